// File: rtl/cic_dec_prog.sv
// cic_dec_prog: programmable CIC decimator (N integrators, N combs, diff delay M).
// Ratio and output shift are loaded at run time. Output is rounded half-up,
// saturated, and carries a one-cycle valid strobe. Comb start-up transient is
// hidden by suppressing the first N*M output strobes after reset or a load.
// Ports:
//   clk, rstn        clock, async active-low reset
//   en, din          input sample qualifier and signed sample
//   cfg_ld           load ratio/shift (if legal) and flush the datapath
//   ratio, shift     decimation ratio (1..RMAX), right shift (0..NMAX-NOUT)
//   valid, dout      output strobe and registered signed output
//   cfg_err          sticky flag: last load carried an illegal value
module cic_dec_prog #(
  parameter int NIN  = 12,
  parameter int N    = 3,
  parameter int M    = 1,
  parameter int RMAX = 64,
  parameter int NMAX = 30,
  parameter int NOUT = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic [NIN-1:0]              din,
  input  logic                        cfg_ld,
  input  logic [$clog2(RMAX+1)-1:0]   ratio,
  input  logic [$clog2(NMAX)-1:0]     shift,
  output logic                        valid,
  output logic [NOUT-1:0]             dout,
  output logic                        cfg_err
);
  localparam int RW = $clog2(RMAX+1);
  localparam int SW = $clog2(NMAX);
  localparam int WW = $clog2(N*M+1);
  localparam logic [RW-1:0] RMAX_V = RW'(RMAX);
  localparam logic [SW-1:0] SHMAX  = SW'(NMAX-NOUT);
  localparam logic signed [NMAX:0] OMAX = (NMAX+1)'((2**(NOUT-1)) - 1);
  localparam logic signed [NMAX:0] OMIN = (NMAX+1)'(-(2**(NOUT-1)));

  logic [RW-1:0] r_act, cnt;
  logic [SW-1:0] sh;
  logic [WW-1:0] warm;

  // ---------------- configuration ----------------
  logic ld_ok;
  assign ld_ok = (ratio != '0) && (ratio <= RMAX_V) && (shift <= SHMAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_act   <= RMAX_V;
      sh      <= SHMAX;
      cfg_err <= 1'b0;
    end else if (cfg_ld) begin
      if (ld_ok) begin
        r_act   <= ratio;
        sh      <= shift;
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  // ---------------- integrators ----------------
  // The whole chain settles combinationally so every stage reflects the same
  // sample after a single edge.
  logic [N-1:0][NMAX-1:0] integ, integ_nx;
  logic [NMAX-1:0]        din_x;
  assign din_x = {{(NMAX-NIN){din[NIN-1]}}, din};

  always_comb begin
    integ_nx    = integ;
    integ_nx[0] = integ[0] + din_x;
    for (int k = 1; k < N; k++) integ_nx[k] = integ[k] + integ_nx[k-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       integ <= '0;
    else if (cfg_ld) integ <= '0;
    else if (en)     integ <= integ_nx;
  end

  // ---------------- decimation counter / strobe pipe ----------------
  // vld_pipe[j] enables comb stage j; vld_pipe[N] enables the output stage.
  logic [N:0]      vld_pipe;
  logic [NMAX-1:0] comb_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      comb_in  <= '0;
      vld_pipe <= '0;
    end else if (cfg_ld) begin
      cnt      <= '0;
      comb_in  <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[N-1:0], 1'b0};
      if (en) begin
        if (cnt == r_act - 1'b1) begin
          cnt         <= '0;
          comb_in     <= integ_nx[N-1];
          vld_pipe[0] <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- combs ----------------
  for (genvar j = 0; j < N; j++) begin : g_comb
    logic [NMAX-1:0]          cin, cout;
    logic [M-1:0][NMAX-1:0]   dly;
    if (j == 0) begin : g_in
      assign cin = comb_in;
    end else begin : g_in
      assign cin = g_comb[j-1].cout;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cout <= '0;
        dly  <= '0;
      end else if (cfg_ld) begin
        cout <= '0;
        dly  <= '0;
      end else if (vld_pipe[j]) begin
        cout <= cin - dly[M-1];
        for (int i = M-1; i > 0; i--) dly[i] <= dly[i-1];
        dly[0] <= cin;
      end
    end
  end

  // ---------------- round / shift / saturate ----------------
  // One guard bit above NMAX so the rounding add cannot wrap.
  logic signed [NMAX:0] ext, rnd, sum, shd;
  logic [NOUT-1:0]      dsat;

  always_comb begin
    ext  = {g_comb[N-1].cout[NMAX-1], g_comb[N-1].cout};
    rnd  = (sh != '0) ? ((NMAX+1)'(1) << (sh - 1'b1)) : '0;
    sum  = ext + rnd;
    shd  = sum >>> sh;
    if (shd > OMAX)      dsat = OMAX[NOUT-1:0];
    else if (shd < OMIN) dsat = OMIN[NOUT-1:0];
    else                 dsat = shd[NOUT-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      warm  <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else if (cfg_ld) begin
      warm  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (vld_pipe[N]) begin
        // Comb delay lines are still filling: count the strobe, keep dout.
        if (warm != WW'(N*M)) begin
          warm <= warm + 1'b1;
        end else begin
          dout  <= dsat;
          valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cic_dec_prog.sv
// tb_cic_dec_prog: randomized/directed bench for cic_dec_prog. The reference
// model computes each decimated output as a direct FIR convolution with the
// CIC impulse response ((1-z^-RM)/(1-z^-1))^N, then rounds/shifts/saturates,
// and schedules it N+1 edges after the group-completing edge.
module tb_cic_dec_prog;
  localparam int NIN = 12, N = 3, M = 1, RMAX = 64, NMAX = 30, NOUT = 16;
  localparam int RW = $clog2(RMAX+1), SW = $clog2(NMAX);

  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, cfg_ld = 1'b0;
  logic [NIN-1:0] din = '0;
  logic [RW-1:0]  ratio = '0;
  logic [SW-1:0]  shift = '0;
  logic           valid, cfg_err;
  logic [NOUT-1:0] dout;

  cic_dec_prog #(.NIN(NIN), .N(N), .M(M), .RMAX(RMAX), .NMAX(NMAX), .NOUT(NOUT)) dut (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .cfg_ld(cfg_ld),
    .ratio(ratio), .shift(shift), .valid(valid), .dout(dout), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; longint val; } pend_t;
  int      m_r, m_s, m_err, m_warm, m_cnt, m_edge;
  logic    m_valid;
  longint  m_dout;
  longint  xs[$];
  longint  h[];
  pend_t   pq[$];

  function automatic void build_h();
    longint nh[];
    h = new[1];
    h[0] = 1;
    for (int st = 0; st < N; st++) begin
      nh = new[h.size() + m_r*M - 1];
      foreach (nh[i]) nh[i] = 0;
      foreach (h[i]) for (int t = 0; t < m_r*M; t++) nh[i+t] += h[i];
      h = nh;
    end
  endfunction

  function automatic longint scale(input longint y);
    longint v;
    v = y;
    if (m_s > 0) v += longint'(1) <<< (m_s-1);
    v = v >>> m_s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic void model_flush();
    xs.delete(); pq.delete();
    m_warm = 0; m_cnt = 0;
  endfunction

  function automatic void model_reset();
    model_flush();
    m_r = RMAX; m_s = NMAX - NOUT; m_err = 0;
    m_valid = 1'b0; m_dout = 0; m_edge = 0;
    build_h();
  endfunction

  function automatic void model_edge();
    pend_t  p;
    longint y;
    int     n;
    m_edge++;
    m_valid = 1'b0;
    if (cfg_ld) begin
      if (int'(ratio) >= 1 && int'(ratio) <= RMAX && int'(shift) <= NMAX-NOUT) begin
        m_r = int'(ratio); m_s = int'(shift); m_err = 0;
        build_h();
      end else begin
        m_err = 1;
      end
      model_flush();
      return;
    end
    if (pq.size() > 0 && pq[0].due == m_edge) begin
      p = pq.pop_front();
      if (m_warm < N*M) m_warm++;
      else begin m_valid = 1'b1; m_dout = p.val; end
    end
    if (en) begin
      xs.push_back(longint'($signed(din)));
      while (xs.size() > h.size()) void'(xs.pop_front());
      m_cnt++;
      if (m_cnt == m_r) begin
        m_cnt = 0;
        n = xs.size() - 1;
        y = 0;
        for (int k = 0; k < h.size() && k <= n; k++) y += h[k] * xs[n-k];
        pq.push_back('{m_edge + N + 1, scale(y)});
      end
    end
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare at negedge.
  task automatic cyc(input logic e, input longint d, input logic ld = 1'b0,
                     input int r = 0, input int s = 0);
    en = e; din = NIN'(d); cfg_ld = ld; ratio = RW'(r); shift = SW'(s);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("valid", valid, m_valid);
    chk("dout", $signed(dout), m_dout);
    chk("cfg_err", cfg_err, m_err);
  endtask

  function automatic longint rnd_din();
    return longint'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_dout", $signed(dout), 0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rstn = 1'b1;

    // DC gain R^N
    cyc(0, 0, 1, 8, 0);
    repeat (120) cyc(1, 1);

    // rounding half-up
    cyc(0, 0, 1, 2, 4);
    repeat (40) cyc(1, 3);
    repeat (40) cyc(1, -3);

    // saturation with integrator wrap
    cyc(0, 0, 1, 64, 0);
    repeat (64*8) cyc(1, 2047);
    repeat (64*8) cyc(1, -2048);

    // impulse response
    cyc(0, 0, 1, 4, 0);
    repeat (24) cyc(1, 0);
    cyc(1, 1);
    repeat (40) cyc(1, 0);

    // config errors: ratio 0, ratio RMAX+1, shift too large, then legal
    cyc(0, 0, 1, 0, 0);
    repeat (30) cyc(1, rnd_din());
    cyc(0, 0, 1, RMAX+1, 3);
    repeat (30) cyc(1, 2);
    cyc(0, 0, 1, 8, NMAX-NOUT+1);
    repeat (10) cyc($urandom_range(0, 1) == 1, rnd_din());
    cyc(0, 0, 1, 5, 2);
    repeat (60) cyc($urandom_range(0, 3) != 0, rnd_din());

    // async reset mid-group
    en = 1'b0;
    #3 rstn = 1'b0;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_dout", $signed(dout), 0);
    chk("arst_cfg_err", cfg_err, 1'b0);
    model_reset();
    #28 rstn = 1'b1;
    @(negedge clk);
    repeat (80) cyc(1, rnd_din());

    // cfg_ld coincident with en: sample dropped, group restarts
    cyc(1, 7, 1, 3, 0);
    repeat (40) cyc($urandom_range(0, 4) != 0, rnd_din());

    // randomized blocks, including R=1 with continuous en
    for (int blk = 0; blk < 12; blk++) begin
      int r, s;
      r = (blk % 4 == 0) ? 1 : $urandom_range(1, 12);
      s = $urandom_range(0, NMAX-NOUT);
      cyc(0, 0, 1, r, s);
      repeat (250) begin
        logic e, ld;
        e  = (blk % 4 == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        ld = ($urandom_range(0, 199) == 0);
        cyc(e, rnd_din(), ld, $urandom_range(0, RMAX+1), $urandom_range(0, NMAX-NOUT));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
